// File: rtl/hex_keypad_scanner.sv
// ---------------------------------------------------------------------------
// hex_keypad_scanner
//   Scans a 4x4 hex keypad by strobing one column low at a time and sampling
//   the rows at the end of each column period. A full four-column scan is
//   classified as no key, one key or several keys. Presses and releases are
//   debounced over whole scans. Each accepted press produces one event, and
//   its hex digit is shifted into an address register.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   col_out    column drive, active-low, exactly one bit low
//   row_in     row sense, active-low, asynchronous to clk
//   key_valid  one-cycle pulse when a debounced press is accepted
//   key_code   last accepted key, row_index*4 + col_index
//   key_held   high from acceptance until debounced release
//   addr_out   hex-entry shift register, newest digit in the low nibble
// ---------------------------------------------------------------------------
module hex_keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int ADDR_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [3:0]        col_out,
  input  logic [3:0]        row_in,
  output logic              key_valid,
  output logic [3:0]        key_code,
  output logic              key_held,
  output logic [ADDR_W-1:0] addr_out
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } cls_t;

  // Classify a full-scan snapshot. Result is {class, key code}. Snapshot bit
  // position is col*4 + row, while the key code is row*4 + col, so the two
  // 2-bit halves of the position are swapped to form the code.
  function automatic logic [5:0] classify(input logic [15:0] snap);
    logic [1:0] ones;
    logic [3:0] pos;
    logic [1:0] cls;
    ones = 2'd0;
    pos  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        pos = 4'(i);
        if (ones != 2'd2) begin
          ones = ones + 2'd1;
        end else begin
          ones = ones;
        end
      end else begin
        pos = pos;
      end
    end
    case (ones)
      2'd0:    cls = CLS_NONE;
      2'd1:    cls = CLS_SINGLE;
      default: cls = CLS_MULTI;
    endcase
    return {cls, pos[1:0], pos[3:2]};
  endfunction

  logic [3:0]       row_meta_r;
  logic [3:0]       row_sync_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       col_idx_r;
  logic [15:0]      snap_r;
  state_t           state_r;
  state_t           state_n;
  logic [3:0]       cand_r;
  logic [3:0]       cand_n;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc_s;

  logic              sample_s;
  logic              scan_done_s;
  logic [1:0]        col_idx_n_s;
  logic [15:0]       col_bits_s;
  logic [15:0]       snap_full_s;
  logic [5:0]        cls_word_s;
  cls_t              cls_s;
  logic [3:0]        cls_code_s;
  logic              accept_s;
  logic [ADDR_W-1:0] addr_shift_s;

  assign sample_s    = (div_r == DIV_LAST);
  assign scan_done_s = sample_s && (col_idx_r == 2'd3);
  assign col_idx_n_s = col_idx_r + 2'd1;
  // Pressed rows of the current column, placed at bits col_idx*4 + row.
  assign col_bits_s  = {12'h000, ~row_sync_r} << {col_idx_r, 2'b00};
  assign snap_full_s = snap_r | col_bits_s;
  assign cls_word_s  = classify(snap_full_s);
  assign cls_s       = cls_t'(cls_word_s[5:4]);
  assign cls_code_s  = cls_word_s[3:0];
  assign cnt_inc_s   = (cnt_r == CNT_DONE) ? cnt_r : (cnt_r + CNT_ONE);

  // A 4-bit register has no room to shift, so it simply takes the new digit.
  generate
    if (ADDR_W == 4) begin : g_addr_narrow
      assign addr_shift_s = cand_n;
    end else begin : g_addr_wide
      assign addr_shift_s = {addr_out[ADDR_W-5:0], cand_n};
    end
  endgenerate

  // Two-flop synchronizer for the asynchronous row inputs; idle rows read high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row_in;
      row_sync_r <= row_meta_r;
    end
  end

  // Column period divider, column index and registered column drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r     <= DIV_ZERO;
      col_idx_r <= 2'd0;
      col_out   <= 4'b1110;
    end else if (sample_s) begin
      div_r     <= DIV_ZERO;
      col_idx_r <= col_idx_n_s;
      col_out   <= ~(4'b0001 << col_idx_n_s);
    end else begin
      div_r     <= div_r + DIV_W'(1);
      col_idx_r <= col_idx_r;
      col_out   <= col_out;
    end
  end

  // Snapshot accumulates each column's rows and clears once the scan is classified.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_r <= 16'h0000;
    end else if (scan_done_s) begin
      snap_r <= 16'h0000;
    end else if (sample_s) begin
      snap_r <= snap_full_s;
    end else begin
      snap_r <= snap_r;
    end
  end

  // Debounce FSM state, candidate key and saturating scan counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cand_r  <= 4'h0;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_n;
      cand_r  <= cand_n;
      cnt_r   <= cnt_n;
    end
  end

  // Debounce FSM next state; only a completed scan can move it.
  always_comb begin
    state_n  = state_r;
    cand_n   = cand_r;
    cnt_n    = cnt_r;
    accept_s = 1'b0;
    if (scan_done_s) begin
      case (state_r)
        IDLE: begin
          if (cls_s == CLS_SINGLE) begin
            cand_n = cls_code_s;
            cnt_n  = CNT_ONE;
            if (CNT_DONE <= CNT_ONE) begin
              accept_s = 1'b1;
              state_n  = HELD;
            end else begin
              state_n  = PRESS_DB;
            end
          end else begin
            state_n = IDLE;
          end
        end
        PRESS_DB: begin
          if (cls_s == CLS_SINGLE) begin
            if (cls_code_s == cand_r) begin
              cnt_n = cnt_inc_s;
              if (cnt_inc_s >= CNT_DONE) begin
                accept_s = 1'b1;
                state_n  = HELD;
              end else begin
                state_n  = PRESS_DB;
              end
            end else begin
              cand_n  = cls_code_s;
              cnt_n   = CNT_ONE;
              state_n = PRESS_DB;
            end
          end else begin
            state_n = IDLE;
          end
        end
        HELD: begin
          // Any key activity keeps the current press held: no repeat, no roll-over.
          if (cls_s == CLS_NONE) begin
            cnt_n = CNT_ONE;
            if (CNT_DONE <= CNT_ONE) begin
              state_n = IDLE;
            end else begin
              state_n = RELEASE_DB;
            end
          end else begin
            state_n = HELD;
          end
        end
        RELEASE_DB: begin
          if (cls_s == CLS_NONE) begin
            cnt_n = cnt_inc_s;
            if (cnt_inc_s >= CNT_DONE) begin
              state_n = IDLE;
            end else begin
              state_n = RELEASE_DB;
            end
          end else begin
            state_n = HELD;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = CNT_ZERO;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Registered key outputs; code and address change only on an accepted press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
      addr_out  <= '0;
    end else begin
      key_valid <= accept_s;
      key_held  <= (state_n == HELD) || (state_n == RELEASE_DB);
      if (accept_s) begin
        key_code <= cand_n;
        addr_out <= addr_shift_s;
      end else begin
        key_code <= key_code;
        addr_out <= addr_out;
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_hex_keypad_scanner
//   Directed bench for hex_keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2,
//   ADDR_W=8. A keypad model drives row_in from a mask of pressed keys and
//   the current column drive. One scan is 16 clocks; stimulus changes are
//   made on scan boundaries counted from reset release.
// ---------------------------------------------------------------------------
module tb_hex_keypad_scanner;

  localparam int SCAN = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_out;
  logic [3:0] row_in;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [7:0] addr_out;

  logic [15:0] key_mask = 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  int hi_cycles = 0;
  logic kv_prev = 1'b0;
  int p0;

  hex_keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(2),
    .ADDR_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col_out(col_out),
    .row_in(row_in),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_held(key_held),
    .addr_out(addr_out)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key (code row*4+col) pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // Count key_valid rising edges and high cycles.
  always @(negedge clk) begin
    if (key_valid) hi_cycles++;
    if (key_valid && !kv_prev) pulses++;
    kv_prev = key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col"},   {28'h0, col_out},  32'h0000000E);
    chk({tag, "_valid"}, {31'h0, key_valid}, 32'h0);
    chk({tag, "_code"},  {28'h0, key_code}, 32'h0);
    chk({tag, "_held"},  {31'h0, key_held}, 32'h0);
    chk({tag, "_addr"},  {24'h0, addr_out}, 32'h0);
  endtask

  initial begin
    logic [3:0] exp_col;
    reset = 1'b0;
    step(3);
    check_reset_outputs("rst");

    // 1: idle scanning; each column lasts 4 clocks starting at column 0.
    reset = 1'b1;
    for (int n = 0; n < 2*SCAN; n++) begin
      exp_col = ~(4'b0001 << ((n / 4) % 4));
      chk("col_seq", {28'h0, col_out}, {28'h0, exp_col});
      step(1);
    end
    step(18*SCAN);
    chk("idle_pulses", pulses, 0);
    chk("idle_addr", {24'h0, addr_out}, 32'h0);

    // 2: key 6 (row1/col2) held for 4 scans gives exactly one event.
    key_mask = 16'h0040;
    step(4*SCAN);
    chk("k6_pulses", pulses, 1);
    chk("k6_code", {28'h0, key_code}, 32'h6);
    chk("k6_held", {31'h0, key_held}, 32'h1);
    chk("k6_addr", {24'h0, addr_out}, 32'h06);

    // 3: release for 3 scans, then key F for 3 scans.
    key_mask = 16'h0000;
    step(3*SCAN);
    chk("rel_held", {31'h0, key_held}, 32'h0);
    chk("rel_code_kept", {28'h0, key_code}, 32'h6);
    key_mask = 16'h8000;
    step(3*SCAN);
    chk("kf_pulses", pulses, 2);
    chk("kf_code", {28'h0, key_code}, 32'hF);
    chk("kf_held", {31'h0, key_held}, 32'h1);
    chk("kf_addr", {24'h0, addr_out}, 32'h6F);

    // 4: a single-scan tap of key 5 is rejected.
    key_mask = 16'h0000;
    step(3*SCAN);
    key_mask = 16'h0020;
    step(SCAN);
    key_mask = 16'h0000;
    step(3*SCAN);
    chk("tap_pulses", pulses, 2);
    chk("tap_addr", {24'h0, addr_out}, 32'h6F);
    chk("tap_held", {31'h0, key_held}, 32'h0);

    // 5: keys 0 and 5 together are ghosting; then key 5 alone is accepted.
    key_mask = 16'h0021;
    step(4*SCAN);
    chk("multi_pulses", pulses, 2);
    chk("multi_held", {31'h0, key_held}, 32'h0);
    p0 = pulses;
    key_mask = 16'h0020;
    step(2*SCAN + 2);
    chk("k5_pulses", pulses - p0, 1);
    chk("k5_code", {28'h0, key_code}, 32'h5);
    chk("k5_addr", {24'h0, addr_out}, 32'hF5);
    chk("k5_held", {31'h0, key_held}, 32'h1);

    // 6: asynchronous reset mid-column while held.
    step(6);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async");
    step(1);
    key_mask = 16'h0000;
    step(2);
    chk("in_rst_col", {28'h0, col_out}, 32'hE);
    reset = 1'b1;
    for (int n = 0; n < 8; n++) begin
      exp_col = ~(4'b0001 << ((n / 4) % 4));
      chk("restart_col", {28'h0, col_out}, {28'h0, exp_col});
      step(1);
    end
    chk("pulse_width", hi_cycles, pulses);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
Scans a 4x4 hex keypad by strobing columns and sampling rows. Debounces presses over whole scans and emits one event per press. Shifts each accepted hex digit into an address register that feeds the core's test_addr input, so memory can be inspected on the seven-segment display without rebuilding.

Parameters:
SCAN_DIV, 100000, clk cycles per column period (1 ms at 100 MHz); must be >= 4.
DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or release; must be >= 1.
ADDR_W, 8, width of addr_out; multiple of 4, >= 4.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
col_out  output  4  column drive, active-low, exactly one bit low at all times
row_in  input  4  row sense, active-low (external pull-ups), asynchronous
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  last accepted key, code = row_index*4 + col_index
key_held  output  1  high from acceptance until debounced release
addr_out  output  ADDR_W  hex-entry shift register

Behaviour:
- Reset (reset=0, async): col_out=4'b1110, key_valid=0, key_code=0, key_held=0, addr_out=0. Divider, column index, snapshot, debounce count and FSM go to IDLE with zero values. Any in-progress scan is discarded.
- row_in passes through a 2-flop synchronizer before use.
- Column sequencing:
  - Divider counts 0..SCAN_DIV-1, then wraps.
  - Column index advances 0->1->2->3->0 on wrap.
  - col_out = ~(4'b0001 << col_idx).
- Sampling:
  - When the divider = SCAN_DIV-1, the inverted synchronized rows are stored into snapshot bits [col_idx*4 + r], r = row.
  - Sampling at end of period gives the settling margin.
- Scan completion: scan_done asserts on the sample of column 3. The classified result is:
  - NONE: zero bits set.
  - SINGLE(k): exactly one bit set; k = row*4 + col.
  - MULTI: two or more bits set (ghosting).
  - The snapshot clears after classification.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. Transitions are evaluated only on scan_done.
  - IDLE:
    - SINGLE(k): capture candidate=k, cnt=1, go to PRESS_DB. If DEBOUNCE_SCANS=1, accept immediately (see accept).
    - NONE or MULTI: stay in IDLE.
  - PRESS_DB:
    - SINGLE(same k): cnt+1. When cnt reaches DEBOUNCE_SCANS, accept.
    - SINGLE(different k): candidate=new k, cnt=1.
    - NONE or MULTI: go to IDLE.
  - Accept:
    - Go to HELD.
    - Next clk: key_valid=1 for exactly one cycle, key_code=candidate, key_held=1.
    - addr_out <= {addr_out[ADDR_W-5:0], candidate}; when ADDR_W=4, addr_out <= candidate.
  - HELD:
    - NONE: cnt=1, go to RELEASE_DB; if DEBOUNCE_SCANS=1, go directly to IDLE.
    - SINGLE (any key, including a different one) or MULTI: stay in HELD. No new event; a key must be released first (no auto-repeat, no roll-over).
  - RELEASE_DB:
    - NONE: cnt+1. At DEBOUNCE_SCANS, go to IDLE with key_held=0.
    - SINGLE or MULTI: go back to HELD.
- key_code and addr_out hold their values between events. They change only on accept or reset.
- Latency from a stable press to key_valid: between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 full scans (4*SCAN_DIV clk each), plus 3 clk (2 synchronizer stages + 1 register).
- Counters are sized with $clog2 and saturate; they never wrap.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=2, ADDR_W=8.
1. Reset, then idle rows (4'b1111) for 20 scans -> col_out cycles 1110,1101,1011,0111 with 4 clk each; key_valid never asserts; addr_out=8'h00.
2. Hold key row1/col2 (row_in[1]=0 while col_out=1011) for 4 scans -> exactly one key_valid pulse; key_code=4'h6; key_held=1; addr_out=8'h06.
3. From scenario 2, release 3 scans, then press row3/col3 for 3 scans -> key_held falls; one pulse with key_code=4'hF; addr_out=8'h6F.
4. Press key 5 for 1 scan only, then release -> no key_valid; FSM returns to IDLE; addr_out unchanged.
5. Press keys 0 and 5 together for 4 scans (MULTI) -> no event. Then keep key 5 alone held for 2 further scans -> one pulse with code 4'h5.
6. Assert reset low mid-column while in HELD -> all outputs return to reset values immediately (asynchronously); after reset is released, scanning restarts at column 0.
